// File: rtl/spi_arb_if.sv
// Requester-side bus of the SPI arbiter: three packed request channels
// plus the shared grant/ack/err/read-data return path.
interface spi_arb_if;
   logic [2:0]  req;
   logic [2:0]  lock;
   logic [8:0]  req_tgt;
   logic [47:0] req_data;
   logic [2:0]  gnt;
   logic [2:0]  ack;
   logic        err;
   logic [15:0] rd_data;

   modport master (
      output req, lock, req_tgt, req_data,
      input  gnt, ack, err, rd_data
   );

   modport slave (
      input  req, lock, req_tgt, req_data,
      output gnt, ack, err, rd_data
   );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between three requesters,
// with locked multi-transaction sequences and per-transaction timeout.
module spi_arb #(
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_arb_if.slave    bus,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   input  logic        spi_ss_n,
   output logic        ch1_ss_n,
   output logic        ch2_ss_n,
   output logic        ch3_ss_n,
   output logic        trig_ss_n,
   output logic        EEP_ss_n
);

   typedef enum logic [2:0] {IDLE, START, WAIT, DONE, HOLD} state_e;

   localparam logic [11:0] TO_LIM = 12'(TIMEOUT);

   state_e      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic [1:0]  cur_q, cur_d;
   logic [1:0]  rr_q, rr_d;
   logic [2:0]  sel_q, sel_d;
   logic [15:0] cmd_q, cmd_d;
   logic [15:0] rd_q, rd_d;
   logic [11:0] cnt_q, cnt_d;
   logic        wrt_q, wrt_d;
   logic [2:0]  ack_q, ack_d;
   logic        err_q, err_d;

   logic        win_vld;
   logic [1:0]  win;
   logic [1:0]  p0, p1, p2;
   logic        load;
   logic [1:0]  load_idx;
   logic [2:0]  load_tgt;
   logic        req_w, lock_w;

   // Search order starts at the round-robin pointer.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      p0 = 2'd0; p1 = 2'd1; p2 = 2'd2;
      case (rr_q)
         2'd1:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd2:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      win_vld = 1'b1;
      win     = p0;
      if (bus.req[p0])      win = p0;
      else if (bus.req[p1]) win = p1;
      else if (bus.req[p2]) win = p2;
      else                  win_vld = 1'b0;
   end

   assign req_w  = |(bus.req & gnt_q);
   assign lock_w = |(bus.lock & gnt_q);

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      cur_d    = cur_q;
      rr_d     = rr_q;
      sel_d    = sel_q;
      cmd_d    = cmd_q;
      rd_d     = rd_q;
      cnt_d    = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
      wrt_d    = 1'b0;
      ack_d    = 3'b000;
      err_d    = 1'b0;
      load     = 1'b0;
      load_idx = cur_q;
      load_tgt = 3'd0;

      case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt_d    = 3'b001 << win;
               cur_d    = win;
               rr_d     = (win == 2'd2) ? 2'd0 : win + 2'd1;
               load     = 1'b1;
               load_idx = win;
               state_d  = START;
            end
         end
         START: begin
            if (sel_q > 3'd4) begin
               ack_d   = gnt_q;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (spi_done) begin
               rd_d    = spi_rd;
               ack_d   = gnt_q;
               state_d = DONE;
            end else if (cnt_q >= TO_LIM) begin
               ack_d   = gnt_q;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (lock_w && !err_q) begin
               state_d = HOLD;
            end else begin
               gnt_d   = 3'b000;
               state_d = IDLE;
            end
         end
         HOLD: begin
            // A fresh request from the lock owner beats its lock release.
            if (req_w) begin
               load    = 1'b1;
               state_d = START;
            end else if (!lock_w) begin
               gnt_d   = 3'b000;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = 3'b000;
            state_d = IDLE;
         end
      endcase

      if (load) begin
         for (int i = 0; i < 3; i++) begin
            if (load_idx == 2'(i)) begin
               cmd_d    = bus.req_data[16*i +: 16];
               load_tgt = bus.req_tgt[3*i +: 3];
            end
         end
         sel_d = load_tgt;
         wrt_d = (load_tgt <= 3'd4);
         cnt_d = 12'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 3'b000;
         cur_q   <= 2'd0;
         rr_q    <= 2'd0;
         sel_q   <= 3'd0;
         cmd_q   <= 16'h0000;
         rd_q    <= 16'h0000;
         cnt_q   <= 12'd0;
         wrt_q   <= 1'b0;
         ack_q   <= 3'b000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cur_q   <= cur_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         cmd_q   <= cmd_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         wrt_q   <= wrt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.ack     = ack_q;
   assign bus.err     = err_q;
   assign bus.rd_data = rd_q;
   assign spi_wrt     = wrt_q;
   assign spi_cmd     = cmd_q;

   // Raw select reaches a slave only while a valid target is granted.
   assign ch1_ss_n  = (gnt_q != 3'b000 && sel_q == 3'd0) ? spi_ss_n : 1'b1;
   assign ch2_ss_n  = (gnt_q != 3'b000 && sel_q == 3'd1) ? spi_ss_n : 1'b1;
   assign ch3_ss_n  = (gnt_q != 3'b000 && sel_q == 3'd2) ? spi_ss_n : 1'b1;
   assign trig_ss_n = (gnt_q != 3'b000 && sel_q == 3'd3) ? spi_ss_n : 1'b1;
   assign EEP_ss_n  = (gnt_q != 3'b000 && sel_q == 3'd4) ? spi_ss_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: a default-timeout instance for the functional
// scenarios and a TIMEOUT=16 instance for the timeout scenario.
module tb_spi_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   spi_arb_if bus();
   spi_arb_if bus_t();

   logic        spi_wrt, spi_done, spi_ss_n;
   logic [15:0] spi_cmd, spi_rd;
   logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;

   logic        spi_wrt_t, spi_done_t, spi_ss_n_t;
   logic [15:0] spi_cmd_t, spi_rd_t;
   logic        ch1_t, ch2_t, ch3_t, trig_t, eep_t;

   int total = 0;
   int bad   = 0;

   spi_arb dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
      .spi_rd(spi_rd), .spi_ss_n(spi_ss_n),
      .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
      .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
   );

   spi_arb #(.TIMEOUT(16)) dut_t (
      .clk(clk), .rst_n(rst_n), .bus(bus_t),
      .spi_wrt(spi_wrt_t), .spi_cmd(spi_cmd_t), .spi_done(spi_done_t),
      .spi_rd(spi_rd_t), .spi_ss_n(spi_ss_n_t),
      .ch1_ss_n(ch1_t), .ch2_ss_n(ch2_t), .ch3_ss_n(ch3_t),
      .trig_ss_n(trig_t), .EEP_ss_n(eep_t)
   );

   wire [4:0] ss_all = {ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.req = '0;   bus.lock = '0;   bus.req_tgt = '0;   bus.req_data = '0;
      bus_t.req = '0; bus_t.lock = '0; bus_t.req_tgt = '0; bus_t.req_data = '0;
      spi_done = 1'b0;   spi_rd = '0;   spi_ss_n = 1'b1;
      spi_done_t = 1'b0; spi_rd_t = '0; spi_ss_n_t = 1'b1;
      #12;
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
      total++; if (bus.ack !== 3'b000 || bus.err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b/%b want 000/0", bus.ack, bus.err); end
      total++; if (bus.rd_data !== 16'h0000 || spi_cmd !== 16'h0000) begin bad++; $display("FAIL reset_data: got rd=%h cmd=%h want 0000/0000", bus.rd_data, spi_cmd); end
      total++; if (spi_wrt !== 1'b0) begin bad++; $display("FAIL reset_wrt: got %b want 0", spi_wrt); end
      total++; if (ss_all !== 5'b11111) begin bad++; $display("FAIL reset_ss: got %b want 11111", ss_all); end
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      int wrt_cnt;
      bit early_ack;
      bus.req_tgt[2:0]   = 3'd3;
      bus.req_data[15:0] = 16'h13A5;
      bus.req            = 3'b001;
      tick;
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL single_gnt: got %b want 001", bus.gnt); end
      total++; if (spi_cmd !== 16'h13A5) begin bad++; $display("FAIL single_cmd: got %h want 13a5", spi_cmd); end
      total++; if (spi_wrt !== 1'b1) begin bad++; $display("FAIL single_wrt: got %b want 1", spi_wrt); end
      wrt_cnt = (spi_wrt === 1'b1) ? 1 : 0;
      spi_ss_n = 1'b0;
      #1;
      total++; if (ss_all !== 5'b11101) begin bad++; $display("FAIL single_ss_route: got %b want 11101", ss_all); end
      early_ack = 1'b0;
      repeat (600) begin
         tick;
         if (spi_wrt === 1'b1) wrt_cnt++;
         if (bus.ack !== 3'b000) early_ack = 1'b1;
      end
      total++; if (wrt_cnt != 1) begin bad++; $display("FAIL single_wrt_pulses: got %0d want 1", wrt_cnt); end
      total++; if (early_ack) begin bad++; $display("FAIL single_early_ack: got ack before spi_done, want none"); end
      spi_done = 1'b1;
      spi_rd   = 16'h00FF;
      tick;
      total++; if (bus.ack !== 3'b001 || bus.err !== 1'b0) begin bad++; $display("FAIL single_ack: got %b/%b want 001/0", bus.ack, bus.err); end
      total++; if (bus.rd_data !== 16'h00FF) begin bad++; $display("FAIL single_rd: got %h want 00ff", bus.rd_data); end
      spi_done = 1'b0;
      spi_ss_n = 1'b1;
      bus.req  = 3'b000;
      #1;
      total++; if (trig_ss_n !== 1'b1) begin bad++; $display("FAIL single_ss_release: got %b want 1", trig_ss_n); end
      tick;
      total++; if (bus.gnt !== 3'b000 || bus.ack !== 3'b000) begin bad++; $display("FAIL single_end: got gnt=%b ack=%b want 000/000", bus.gnt, bus.ack); end
   endtask

   task automatic test_fairness;
      logic [15:0] fd [3];
      int order [4];
      int w;
      fd[0] = 16'hA000; fd[1] = 16'hB001; fd[2] = 16'hC002;
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      bus.lock     = 3'b000;
      bus.req_tgt  = {3'd2, 3'd1, 3'd0};
      bus.req_data = {fd[2], fd[1], fd[0]};
      bus.req      = 3'b111;
      for (int n = 0; n < 4; n++) begin
         w = order[n];
         tick;
         total++; if (bus.gnt !== 3'(1 << w)) begin bad++; $display("FAIL fair_gnt%0d: got %b want %b", n, bus.gnt, 3'(1 << w)); end
         total++; if (spi_cmd !== fd[w]) begin bad++; $display("FAIL fair_cmd%0d: got %h want %h", n, spi_cmd, fd[w]); end
         tick;
         spi_done = 1'b1;
         spi_rd   = 16'h5A00 + 16'(n);
         tick;
         spi_done = 1'b0;
         total++; if (bus.ack !== 3'(1 << w)) begin bad++; $display("FAIL fair_ack%0d: got %b want %b", n, bus.ack, 3'(1 << w)); end
         bus.req[w] = 1'b0;
         tick;
         total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL fair_release%0d: got %b want 000", n, bus.gnt); end
         bus.req[w] = 1'b1;
      end
      bus.req = 3'b000;
      tick;
   endtask

   task automatic test_lock;
      bus.req_tgt[8:6]    = 3'd4;
      bus.req_data[47:32] = 16'h032A;
      bus.req_tgt[5:3]    = 3'd1;
      bus.req_data[31:16] = 16'h1111;
      bus.lock            = 3'b100;
      bus.req             = 3'b100;
      tick;
      total++; if (bus.gnt !== 3'b100 || spi_cmd !== 16'h032A) begin bad++; $display("FAIL lock_first: got gnt=%b cmd=%h want 100/032a", bus.gnt, spi_cmd); end
      bus.req[1] = 1'b1;
      spi_ss_n   = 1'b0;
      #1;
      total++; if (ss_all !== 5'b11110) begin bad++; $display("FAIL lock_ss1: got %b want 11110", ss_all); end
      tick;
      spi_done = 1'b1;
      spi_rd   = 16'hBEEF;
      tick;
      total++; if (bus.ack !== 3'b100) begin bad++; $display("FAIL lock_ack1: got %b want 100", bus.ack); end
      spi_done   = 1'b0;
      spi_ss_n   = 1'b1;
      bus.req[2] = 1'b0;
      tick;
      total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL lock_hold: got %b want 100", bus.gnt); end
      bus.req_data[47:32] = 16'h0000;
      bus.req[2]          = 1'b1;
      tick;
      total++; if (bus.gnt !== 3'b100 || spi_cmd !== 16'h0000 || spi_wrt !== 1'b1) begin bad++; $display("FAIL lock_second: got gnt=%b cmd=%h wrt=%b want 100/0000/1", bus.gnt, spi_cmd, spi_wrt); end
      spi_ss_n = 1'b0;
      #1;
      total++; if (ss_all !== 5'b11110) begin bad++; $display("FAIL lock_ss2: got %b want 11110", ss_all); end
      tick;
      spi_done = 1'b1;
      spi_rd   = 16'h1234;
      tick;
      total++; if (bus.ack !== 3'b100 || bus.rd_data !== 16'h1234) begin bad++; $display("FAIL lock_ack2: got ack=%b rd=%h want 100/1234", bus.ack, bus.rd_data); end
      spi_done   = 1'b0;
      spi_ss_n   = 1'b1;
      bus.req[2] = 1'b0;
      bus.lock   = 3'b000;
      tick;
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL lock_idle: got %b want 000", bus.gnt); end
      tick;
      total++; if (bus.gnt !== 3'b010 || spi_cmd !== 16'h1111) begin bad++; $display("FAIL lock_next: got gnt=%b cmd=%h want 010/1111", bus.gnt, spi_cmd); end
      tick;
      spi_done = 1'b1;
      spi_rd   = 16'h0777;
      tick;
      total++; if (bus.ack !== 3'b010) begin bad++; $display("FAIL lock_ack3: got %b want 010", bus.ack); end
      spi_done = 1'b0;
      bus.req  = 3'b000;
      tick;
   endtask

   task automatic test_invalid;
      bus.req_tgt[2:0]   = 3'd6;
      bus.req_data[15:0] = 16'h5555;
      bus.req            = 3'b001;
      spi_ss_n           = 1'b0;
      tick;
      total++; if (bus.gnt !== 3'b001 || spi_wrt !== 1'b0 || bus.ack !== 3'b000) begin bad++; $display("FAIL inv_start: got gnt=%b wrt=%b ack=%b want 001/0/000", bus.gnt, spi_wrt, bus.ack); end
      total++; if (ss_all !== 5'b11111) begin bad++; $display("FAIL inv_ss: got %b want 11111", ss_all); end
      tick;
      total++; if (bus.ack !== 3'b001 || bus.err !== 1'b1 || spi_wrt !== 1'b0) begin bad++; $display("FAIL inv_ack_err: got ack=%b err=%b wrt=%b want 001/1/0", bus.ack, bus.err, spi_wrt); end
      bus.req  = 3'b000;
      spi_ss_n = 1'b1;
      tick;
      total++; if (bus.gnt !== 3'b000 || bus.ack !== 3'b000 || bus.err !== 1'b0) begin bad++; $display("FAIL inv_end: got gnt=%b ack=%b err=%b want 000/000/0", bus.gnt, bus.ack, bus.err); end
   endtask

   task automatic test_timeout;
      bit early_ack;
      bus_t.req_tgt[2:0]   = 3'd0;
      bus_t.req_data[15:0] = 16'h0101;
      bus_t.req            = 3'b001;
      tick;
      tick;
      spi_done_t = 1'b1;
      spi_rd_t   = 16'hABCD;
      tick;
      total++; if (bus_t.ack !== 3'b001 || bus_t.rd_data !== 16'hABCD) begin bad++; $display("FAIL to_pre: got ack=%b rd=%h want 001/abcd", bus_t.ack, bus_t.rd_data); end
      spi_done_t = 1'b0;
      bus_t.req  = 3'b000;
      tick;
      bus_t.req_tgt[5:3]    = 3'd1;
      bus_t.req_data[31:16] = 16'h2222;
      bus_t.req             = 3'b010;
      tick;
      total++; if (spi_wrt_t !== 1'b1) begin bad++; $display("FAIL to_wrt: got %b want 1", spi_wrt_t); end
      early_ack = 1'b0;
      repeat (16) begin
         tick;
         if (bus_t.ack !== 3'b000) early_ack = 1'b1;
      end
      total++; if (early_ack) begin bad++; $display("FAIL to_early: got ack before spi_wrt+17, want none"); end
      tick;
      total++; if (bus_t.ack !== 3'b010 || bus_t.err !== 1'b1) begin bad++; $display("FAIL to_ack_err: got ack=%b err=%b want 010/1", bus_t.ack, bus_t.err); end
      total++; if (bus_t.rd_data !== 16'hABCD) begin bad++; $display("FAIL to_rd_kept: got %h want abcd", bus_t.rd_data); end
      bus_t.req = 3'b000;
      tick;
      total++; if (bus_t.gnt !== 3'b000) begin bad++; $display("FAIL to_idle: got %b want 000", bus_t.gnt); end
      bus_t.req_tgt[8:6]    = 3'd2;
      bus_t.req_data[47:32] = 16'h3333;
      bus_t.req             = 3'b100;
      tick;
      total++; if (bus_t.gnt !== 3'b100 || spi_wrt_t !== 1'b1 || spi_cmd_t !== 16'h3333) begin bad++; $display("FAIL to_next: got gnt=%b wrt=%b cmd=%h want 100/1/3333", bus_t.gnt, spi_wrt_t, spi_cmd_t); end
      tick;
      spi_done_t = 1'b1;
      tick;
      spi_done_t = 1'b0;
      bus_t.req  = 3'b000;
      tick;
   endtask

   task automatic test_reset_mid;
      bus.req_tgt   = {3'd2, 3'd1, 3'd0};
      bus.req_data  = {16'h9992, 16'h7777, 16'h9990};
      bus.req       = 3'b010;
      tick;
      tick;
      spi_ss_n = 1'b0;
      tick;
      tick;
      total++; if (ch2_ss_n !== 1'b0 || bus.gnt !== 3'b010) begin bad++; $display("FAIL mid_active: got ch2=%b gnt=%b want 0/010", ch2_ss_n, bus.gnt); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.gnt !== 3'b000 || spi_wrt !== 1'b0 || bus.ack !== 3'b000) begin bad++; $display("FAIL mid_rst_ctl: got gnt=%b wrt=%b ack=%b want 000/0/000", bus.gnt, spi_wrt, bus.ack); end
      total++; if (ss_all !== 5'b11111) begin bad++; $display("FAIL mid_rst_ss: got %b want 11111", ss_all); end
      total++; if (bus.rd_data !== 16'h0000 || bus_t.rd_data !== 16'h0000) begin bad++; $display("FAIL mid_rst_rd: got %h/%h want 0000/0000", bus.rd_data, bus_t.rd_data); end
      spi_ss_n = 1'b1;
      bus.req  = 3'b111;
      #1;
      rst_n = 1'b1;
      tick;
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL mid_first_gnt: got %b want 001", bus.gnt); end
      bus.req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_invalid();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
